// File: rtl/hand_pkg.sv
// Shared types and default layout for the hand slot controller and its scan locator.
package hand_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_REMOVE = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_SELECT = 2'd3
  } hand_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } hand_state_e;

  typedef logic [5:0] card_t;
  typedef logic [3:0] slot_idx_t;

  localparam int MAX_CARDS_DEF = 15;
  localparam int X0_DEF        = 170;
  localparam int Y0_DEF        = 410;
  localparam int PITCH_DEF     = 40;
  localparam int CARD_W_DEF    = 30;
  localparam int CARD_H_DEF    = 50;

endpackage

// File: rtl/hand_slot_locator.sv
// Combinational map from scan position to hand slot, using constant slot edges (no divider).
module hand_slot_locator
  import hand_pkg::*;
#(
  parameter int MAX_CARDS = MAX_CARDS_DEF,
  parameter int X0        = X0_DEF,
  parameter int Y0        = Y0_DEF,
  parameter int PITCH     = PITCH_DEF,
  parameter int CARD_W    = CARD_W_DEF,
  parameter int CARD_H    = CARD_H_DEF
) (
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  slot_idx_t  i_count,
  output logic       o_hit,
  output slot_idx_t  o_slot,
  output logic [4:0] o_u,
  output logic [5:0] o_v
);

  function automatic logic [9:0] slot_left(input int k);
    return 10'(X0 + k * PITCH);
  endfunction

  logic row_hit;

  // Slots never overlap, so at most one iteration can claim the hit.
  always_comb begin
    o_hit   = 1'b0;
    o_slot  = '0;
    o_u     = '0;
    o_v     = '0;
    row_hit = (i_y >= 10'(Y0)) && (i_y < 10'(Y0 + CARD_H));
    for (int k = 0; k < MAX_CARDS; k++) begin
      if (row_hit && (slot_idx_t'(k) < i_count) &&
          (i_x >= slot_left(k)) && (i_x < slot_left(k) + 10'(CARD_W))) begin
        o_hit  = 1'b1;
        o_slot = slot_idx_t'(k);
        o_u    = 5'(i_x - slot_left(k));
        o_v    = 6'(i_y - 10'(Y0));
      end
    end
  end

endmodule

// File: rtl/hand_slot_controller.sv
// Player hand: command-edited working array, frame-synchronous display shadow, and
// registered per-pixel slot lookup for the card renderer.
module hand_slot_controller
  import hand_pkg::*;
#(
  parameter int MAX_CARDS = MAX_CARDS_DEF,
  parameter int X0        = X0_DEF,
  parameter int Y0        = Y0_DEF,
  parameter int PITCH     = PITCH_DEF,
  parameter int CARD_W    = CARD_W_DEF,
  parameter int CARD_H    = CARD_H_DEF
) (
  input  logic       i_clk_25M,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [5:0] i_cmd_card,
  input  logic [3:0] i_cmd_idx,
  output logic       o_cmd_done,
  output logic       o_cmd_err,
  output logic [3:0] o_card_count,
  input  logic       i_frame_start,
  input  logic [9:0] i_x_cnt,
  input  logic [9:0] i_y_cnt,
  output logic       o_pix_hit,
  output logic [5:0] o_pix_card,
  output logic       o_pix_sel,
  output logic [4:0] o_pix_u,
  output logic [5:0] o_pix_v
);

  localparam slot_idx_t FULL_COUNT = slot_idx_t'(MAX_CARDS);

  hand_state_e state_q, state_d;
  card_t       work_q [MAX_CARDS];
  card_t       work_d [MAX_CARDS];
  card_t       disp_q [MAX_CARDS];
  card_t       disp_d [MAX_CARDS];
  slot_idx_t   count_q, count_d, disp_count_q, disp_count_d;
  slot_idx_t   sel_q, sel_d, disp_sel_q, disp_sel_d;
  logic        sel_valid_q, sel_valid_d, disp_sel_valid_q, disp_sel_valid_d;
  logic        dirty_q, dirty_d, err_q, err_d;
  slot_idx_t   k_q, k_d, idx_q, idx_d;
  logic        pix_hit_q, pix_hit_d, pix_sel_q, pix_sel_d;
  card_t       pix_card_q, pix_card_d;
  logic [4:0]  pix_u_q, pix_u_d;
  logic [5:0]  pix_v_q, pix_v_d;
  logic        success;

  logic        loc_hit;
  slot_idx_t   loc_slot;
  logic [4:0]  loc_u;
  logic [5:0]  loc_v;

  hand_slot_locator #(
    .MAX_CARDS(MAX_CARDS), .X0(X0), .Y0(Y0),
    .PITCH(PITCH), .CARD_W(CARD_W), .CARD_H(CARD_H)
  ) u_locator (
    .i_x     (i_x_cnt),
    .i_y     (i_y_cnt),
    .i_count (disp_count_q),
    .o_hit   (loc_hit),
    .o_slot  (loc_slot),
    .o_u     (loc_u),
    .o_v     (loc_v)
  );

  assign o_cmd_ready  = (state_q == ST_IDLE);
  assign o_cmd_done   = (state_q == ST_DONE);
  assign o_cmd_err    = (state_q == ST_DONE) && err_q;
  assign o_card_count = count_q;
  assign o_pix_hit    = pix_hit_q;
  assign o_pix_card   = pix_card_q;
  assign o_pix_sel    = pix_sel_q;
  assign o_pix_u      = pix_u_q;
  assign o_pix_v      = pix_v_q;

  always_comb begin
    state_d          = state_q;
    work_d           = work_q;
    disp_d           = disp_q;
    count_d          = count_q;
    disp_count_d     = disp_count_q;
    sel_d            = sel_q;
    sel_valid_d      = sel_valid_q;
    disp_sel_d       = disp_sel_q;
    disp_sel_valid_d = disp_sel_valid_q;
    dirty_d          = dirty_q;
    err_d            = err_q;
    k_d              = k_q;
    idx_d            = idx_q;
    success          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
          case (hand_op_e'(i_cmd_op))
            OP_ADD: begin
              if (count_q == FULL_COUNT) begin
                err_d = 1'b1;
              end else begin
                work_d[count_q] = i_cmd_card;
                count_d         = count_q + 4'd1;
                success         = 1'b1;
              end
            end
            OP_REMOVE: begin
              if (i_cmd_idx >= count_q) begin
                err_d = 1'b1;
              end else begin
                state_d = ST_SHIFT;
                k_d     = i_cmd_idx;
                idx_d   = i_cmd_idx;
              end
            end
            OP_CLEAR: begin
              for (int i = 0; i < MAX_CARDS; i++) work_d[i] = '0;
              count_d     = '0;
              sel_valid_d = 1'b0;
              success     = 1'b1;
            end
            default: begin
              if (i_cmd_idx >= count_q) begin
                err_d = 1'b1;
              end else begin
                sel_d       = i_cmd_idx;
                sel_valid_d = 1'b1;
                success     = 1'b1;
              end
            end
          endcase
        end
      end
      // One slot moves down per cycle; the last occupied slot is cleared on the final step.
      ST_SHIFT: begin
        if (k_q == count_q - 4'd1) begin
          work_d[k_q] = '0;
          count_d     = count_q - 4'd1;
          if (sel_valid_q && (sel_q == idx_q)) sel_valid_d = 1'b0;
          else if (sel_valid_q && (sel_q > idx_q)) sel_d = sel_q - 4'd1;
          success = 1'b1;
          state_d = ST_DONE;
        end else begin
          work_d[k_q] = work_q[k_q + 4'd1];
          k_d         = k_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Commit snapshots the pre-edit registers; an edit landing on the same edge re-arms dirty.
    if (i_frame_start && dirty_q && (state_q != ST_SHIFT)) begin
      disp_d           = work_q;
      disp_count_d     = count_q;
      disp_sel_d       = sel_q;
      disp_sel_valid_d = sel_valid_q;
      dirty_d          = 1'b0;
    end
    if (success) dirty_d = 1'b1;
  end

  always_comb begin
    pix_hit_d  = loc_hit;
    pix_card_d = loc_hit ? disp_q[loc_slot] : '0;
    pix_sel_d  = loc_hit && disp_sel_valid_q && (disp_sel_q == loc_slot);
    pix_u_d    = loc_u;
    pix_v_d    = loc_v;
  end

  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= ST_IDLE;
      for (int i = 0; i < MAX_CARDS; i++) begin
        work_q[i] <= '0;
        disp_q[i] <= '0;
      end
      count_q          <= '0;
      disp_count_q     <= '0;
      sel_q            <= '0;
      sel_valid_q      <= 1'b0;
      disp_sel_q       <= '0;
      disp_sel_valid_q <= 1'b0;
      dirty_q          <= 1'b0;
      err_q            <= 1'b0;
      k_q              <= '0;
      idx_q            <= '0;
      pix_hit_q        <= 1'b0;
      pix_card_q       <= '0;
      pix_sel_q        <= 1'b0;
      pix_u_q          <= '0;
      pix_v_q          <= '0;
    end else begin
      state_q          <= state_d;
      work_q           <= work_d;
      disp_q           <= disp_d;
      count_q          <= count_d;
      disp_count_q     <= disp_count_d;
      sel_q            <= sel_d;
      sel_valid_q      <= sel_valid_d;
      disp_sel_q       <= disp_sel_d;
      disp_sel_valid_q <= disp_sel_valid_d;
      dirty_q          <= dirty_d;
      err_q            <= err_d;
      k_q              <= k_d;
      idx_q            <= idx_d;
      pix_hit_q        <= pix_hit_d;
      pix_card_q       <= pix_card_d;
      pix_sel_q        <= pix_sel_d;
      pix_u_q          <= pix_u_d;
      pix_v_q          <= pix_v_d;
    end
  end

endmodule

// File: tb/tb_hand_slot_controller.sv
// Directed, table-driven bench for hand_slot_controller: commands, commit timing, pixel lookup.
module tb_hand_slot_controller;
  import hand_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_card;
  logic [3:0] cmd_idx;
  logic       cmd_done;
  logic       cmd_err;
  logic [3:0] card_count;
  logic       frame_start;
  logic [9:0] x_cnt;
  logic [9:0] y_cnt;
  logic       pix_hit;
  logic [5:0] pix_card;
  logic       pix_sel;
  logic [4:0] pix_u;
  logic [5:0] pix_v;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] op;
    logic [5:0] card;
    logic [3:0] idx;
    int         exp_err;
    int         exp_count;
    int         exp_lat;
  } cmd_vec_t;

  typedef struct {
    int x;
    int y;
    int exp_hit;
    int exp_card;
    int exp_sel;
    int exp_u;
    int exp_v;
  } pix_vec_t;

  cmd_vec_t cmd_tab[$];
  pix_vec_t pix_tab[$];

  always #20 clk = ~clk;

  hand_slot_controller dut (
    .i_clk_25M     (clk),
    .i_rst_n       (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_op      (cmd_op),
    .i_cmd_card    (cmd_card),
    .i_cmd_idx     (cmd_idx),
    .o_cmd_done    (cmd_done),
    .o_cmd_err     (cmd_err),
    .o_card_count  (card_count),
    .i_frame_start (frame_start),
    .i_x_cnt       (x_cnt),
    .i_y_cnt       (y_cnt),
    .o_pix_hit     (pix_hit),
    .o_pix_card    (pix_card),
    .o_pix_sel     (pix_sel),
    .o_pix_u       (pix_u),
    .o_pix_v       (pix_v)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!cmd_ready) check_output({tag, " ready timeout"}, 0, 1);
  endtask

  // Issues one command and returns cycles from the accepting edge to the done pulse.
  task automatic apply_stimulus(input logic [1:0] op, input logic [5:0] card,
                                input logic [3:0] idx, output int lat, output int err_flag);
    wait_ready("cmd");
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_card  = card;
    cmd_idx   = idx;
    tick();
    cmd_valid = 1'b0;
    lat       = 1;
    while (!cmd_done && lat < 50) begin
      tick();
      lat++;
    end
    err_flag = int'(cmd_err);
    if (!cmd_done) check_output("done timeout", 0, 1);
  endtask

  task automatic add_cmd(input logic [1:0] op, input logic [5:0] card, input logic [3:0] idx,
                         input int e, input int c, input int l);
    cmd_vec_t v;
    v.op = op; v.card = card; v.idx = idx;
    v.exp_err = e; v.exp_count = c; v.exp_lat = l;
    cmd_tab.push_back(v);
  endtask

  task automatic run_cmd_tab(input string tag);
    int lat;
    int e;
    foreach (cmd_tab[i]) begin
      apply_stimulus(cmd_tab[i].op, cmd_tab[i].card, cmd_tab[i].idx, lat, e);
      check_output($sformatf("%s[%0d] err", tag, i), e, cmd_tab[i].exp_err);
      check_output($sformatf("%s[%0d] count", tag, i), int'(card_count), cmd_tab[i].exp_count);
      check_output($sformatf("%s[%0d] latency", tag, i), lat, cmd_tab[i].exp_lat);
    end
    cmd_tab.delete();
  endtask

  task automatic add_pix(input int x, input int y, input int h, input int c,
                         input int s, input int u, input int v);
    pix_vec_t p;
    p.x = x; p.y = y; p.exp_hit = h; p.exp_card = c;
    p.exp_sel = s; p.exp_u = u; p.exp_v = v;
    pix_tab.push_back(p);
  endtask

  task automatic run_pix_tab(input string tag);
    foreach (pix_tab[i]) begin
      x_cnt = 10'(pix_tab[i].x);
      y_cnt = 10'(pix_tab[i].y);
      tick();
      check_output($sformatf("%s(%0d,%0d) hit", tag, pix_tab[i].x, pix_tab[i].y),
                   int'(pix_hit), pix_tab[i].exp_hit);
      check_output($sformatf("%s(%0d,%0d) card", tag, pix_tab[i].x, pix_tab[i].y),
                   int'(pix_card), pix_tab[i].exp_card);
      check_output($sformatf("%s(%0d,%0d) sel", tag, pix_tab[i].x, pix_tab[i].y),
                   int'(pix_sel), pix_tab[i].exp_sel);
      check_output($sformatf("%s(%0d,%0d) u", tag, pix_tab[i].x, pix_tab[i].y),
                   int'(pix_u), pix_tab[i].exp_u);
      check_output($sformatf("%s(%0d,%0d) v", tag, pix_tab[i].x, pix_tab[i].y),
                   int'(pix_v), pix_tab[i].exp_v);
    end
    pix_tab.delete();
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Accepts a REMOVE by hand so the caller can interfere while the array is shifting.
  task automatic start_remove(input logic [3:0] idx);
    wait_ready("remove");
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_card  = '0;
    cmd_idx   = idx;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int e;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_card    = '0;
    cmd_idx     = '0;
    frame_start = 1'b0;
    x_cnt       = 10'd170;
    y_cnt       = 10'd410;
    tick();
    tick();
    check_output("reset ready", int'(cmd_ready), 1);
    check_output("reset done", int'(cmd_done), 0);
    check_output("reset count", int'(card_count), 0);
    check_output("reset pix_hit", int'(pix_hit), 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] three adds, display held until frame start");
    add_cmd(2'd0, 6'd5, 4'd0, 0, 1, 1);
    add_cmd(2'd0, 6'd9, 4'd0, 0, 2, 1);
    add_cmd(2'd0, 6'd12, 4'd0, 0, 3, 1);
    run_cmd_tab("add3");
    add_pix(170, 410, 0, 0, 0, 0, 0);
    run_pix_tab("precommit");
    frame_pulse();

    $display("[TB] pixel lookup after commit");
    add_pix(170, 410, 1, 5, 0, 0, 0);
    add_pix(210, 410, 1, 9, 0, 0, 0);
    add_pix(245, 410, 0, 0, 0, 0, 0);
    add_pix(279, 459, 1, 12, 0, 29, 49);
    add_pix(280, 410, 0, 0, 0, 0, 0);
    add_pix(250, 460, 0, 0, 0, 0, 0);
    add_pix(290, 410, 0, 0, 0, 0, 0);
    add_pix(169, 410, 0, 0, 0, 0, 0);
    add_pix(175, 409, 0, 0, 0, 0, 0);
    run_pix_tab("scan");

    $display("[TB] select then remove with shift");
    add_cmd(2'd0, 6'd7, 4'd0, 0, 4, 1);
    add_cmd(2'd3, 6'd0, 4'd3, 0, 4, 1);
    add_cmd(2'd1, 6'd0, 4'd1, 0, 3, 4);
    run_cmd_tab("remove");
    frame_pulse();
    add_pix(170, 410, 1, 5, 0, 0, 0);
    add_pix(210, 420, 1, 12, 0, 0, 10);
    add_pix(255, 415, 1, 7, 1, 5, 5);
    add_pix(290, 410, 0, 0, 0, 0, 0);
    run_pix_tab("shifted");

    $display("[TB] full hand and rejected commands");
    add_cmd(2'd2, 6'd0, 4'd0, 0, 0, 1);
    for (int i = 0; i < 15; i++) add_cmd(2'd0, 6'(i + 1), 4'd0, 0, i + 1, 1);
    add_cmd(2'd0, 6'd63, 4'd0, 1, 15, 1);
    add_cmd(2'd1, 6'd0, 4'd15, 1, 15, 1);
    add_cmd(2'd3, 6'd0, 4'd15, 1, 15, 1);
    run_cmd_tab("full");
    frame_pulse();
    add_pix(730, 410, 1, 15, 0, 0, 0);
    add_pix(759, 459, 1, 15, 0, 29, 49);
    add_pix(760, 410, 0, 0, 0, 0, 0);
    run_pix_tab("full");

    $display("[TB] frame start during shift is deferred");
    apply_stimulus(2'd3, 6'd0, 4'd14, lat, e);
    check_output("select14 err", e, 0);
    start_remove(4'd0);
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      lat++;
    end
    frame_pulse();
    lat++;
    while (!cmd_done && lat < 60) begin
      tick();
      lat++;
    end
    check_output("remove0 latency", lat, 16);
    check_output("remove0 err", int'(cmd_err), 0);
    check_output("remove0 count", int'(card_count), 14);
    add_pix(170, 410, 1, 1, 0, 0, 0);
    add_pix(730, 410, 1, 15, 0, 0, 0);
    run_pix_tab("deferred");
    frame_pulse();
    add_pix(170, 410, 1, 2, 0, 0, 0);
    add_pix(690, 410, 1, 15, 1, 0, 0);
    add_pix(730, 410, 0, 0, 0, 0, 0);
    run_pix_tab("committed");

    $display("[TB] reset in the middle of a shift");
    start_remove(4'd0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_output("midreset count", int'(card_count), 0);
    check_output("midreset done", int'(cmd_done), 0);
    check_output("midreset err", int'(cmd_err), 0);
    check_output("midreset ready", int'(cmd_ready), 1);
    check_output("midreset pix_hit", int'(pix_hit), 0);
    check_output("midreset pix_card", int'(pix_card), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_output("postreset ready", int'(cmd_ready), 1);
    check_output("postreset count", int'(card_count), 0);
    add_pix(170, 410, 0, 0, 0, 0, 0);
    run_pix_tab("postreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
